// File: rtl/fir_sample_feeder.sv
// Sample feeder for a single-sample-at-a-time FIR: queues upstream samples in a
// small FIFO and strobes them into the FIR one by one, waiting for each result.
module fir_sample_feeder #(
    parameter int InputWidth = 16,
    parameter int FifoDepth  = 8,
    parameter int Timeout    = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [InputWidth-1:0]      s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [InputWidth-1:0]      fir_din,
    output logic                       fir_input_valid,
    input  logic                       fir_output_valid,
    output logic                       busy,
    output logic [$clog2(FifoDepth):0] fifo_count,
    output logic                       timeout_err,
    output logic [15:0]                samples_issued
);
    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;
    localparam int TW = (Timeout > 2) ? $clog2(Timeout) : 1;

    localparam logic [CW-1:0] DEPTH    = CW'(FifoDepth);
    localparam logic [TW-1:0] TMO_LAST = TW'(Timeout - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [InputWidth-1:0] mem [FifoDepth];

    logic [1:0]            state_reg, state_next;
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]         count_reg, count_next;
    logic [InputWidth-1:0] din_reg;
    logic [TW-1:0]         tmo_reg, tmo_next;
    logic                  err_reg, err_next;
    logic [15:0]           issued_reg, issued_next;
    logic                  push, pop;

    assign s_ready         = (count_reg < DEPTH);
    assign push            = s_valid && s_ready;
    assign fir_din         = din_reg;
    assign fir_input_valid = (state_reg == ST_ISSUE);
    assign busy            = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign fifo_count      = count_reg;
    assign timeout_err     = err_reg;
    assign samples_issued  = issued_reg;

    // Pops are decided from the registered count only, so a sample written on
    // this edge into an empty FIFO cannot be issued before the next edge.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        tmo_next    = tmo_reg;
        err_next    = err_reg;
        issued_next = issued_reg;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                    tmo_next   = '0;
                end
            end
            ST_ISSUE: begin
                state_next  = ST_WAIT;
                issued_next = issued_reg + 16'd1;
            end
            ST_WAIT: begin
                if (fir_output_valid) begin
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = ST_ISSUE;
                        tmo_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            din_reg    <= '0;
            tmo_reg    <= '0;
            err_reg    <= 1'b0;
            issued_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            tmo_reg    <= tmo_next;
            err_reg    <= err_next;
            issued_reg <= issued_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                din_reg    <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomised bench for fir_sample_feeder: a queue-based reference model is
// compared against the DUT every cycle, plus literal checks on directed scenarios.
module tb_fir_sample_feeder;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int TO = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] fir_din;
    logic         fir_input_valid;
    logic         fir_output_valid;
    logic         busy;
    logic [3:0]   fifo_count;
    logic         timeout_err;
    logic [15:0]  samples_issued;

    fir_sample_feeder #(.InputWidth(W), .FifoDepth(D), .Timeout(TO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_din(fir_din), .fir_input_valid(fir_input_valid),
        .fir_output_valid(fir_output_valid), .busy(busy), .fifo_count(fifo_count),
        .timeout_err(timeout_err), .samples_issued(samples_issued)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus "strobing / waiting / idle" bookkeeping.
    logic [W-1:0] q[$];
    logic [W-1:0] accepted[$];
    logic [W-1:0] got[$];
    bit           m_strobe = 0;
    bit           m_wait   = 0;
    bit           m_err    = 0;
    bit           m_push;
    int           m_waitn  = 0;
    logic [W-1:0] m_din    = '0;
    logic [15:0]  m_issued = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            accepted.delete();
            m_strobe = 0; m_wait = 0; m_err = 0; m_waitn = 0;
            m_din = '0; m_issued = '0;
        end else begin
            m_push = s_valid && (q.size() < D);
            if (m_strobe) begin
                m_strobe = 0; m_wait = 1; m_waitn = 0; m_issued++;
            end else if (m_wait) begin
                if (fir_output_valid) begin
                    m_wait = 0;
                    if (q.size() > 0) begin m_din = q.pop_front(); m_strobe = 1; end
                end else begin
                    m_waitn++;
                    if (m_waitn == TO) begin m_err = 1; m_wait = 0; end
                end
            end else if (q.size() > 0) begin
                m_din = q.pop_front(); m_strobe = 1;
            end
            if (m_push) begin
                q.push_back(s_data);
                accepted.push_back(s_data);
            end
        end
    end

    always @(negedge clk) begin
        check("s_ready", s_ready, q.size() < D);
        check("fifo_count", fifo_count, q.size());
        check("fir_input_valid", fir_input_valid, m_strobe);
        check("fir_din", fir_din, m_din);
        check("busy", busy, m_strobe || m_wait);
        check("timeout_err", timeout_err, m_err);
        check("samples_issued", samples_issued, m_issued);
        if (fir_input_valid === 1'b1) got.push_back(fir_din);
    end

    // FIR stand-in: answers resp_delay cycles after each strobe (0 = never).
    int resp_delay = 10;
    bit resp_rand  = 0;
    bit resp_noise = 0;
    int resp_cnt   = 0;

    initial begin
        fir_output_valid = 1'b0;
        forever begin
            @(negedge clk);
            fir_output_valid = 1'b0;
            if (rst) begin
                resp_cnt = 0;
            end else if (fir_input_valid) begin
                if (resp_rand) resp_cnt = ($urandom_range(9) == 0) ? 200 : int'($urandom_range(12, 1));
                else resp_cnt = resp_delay;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) fir_output_valid = 1'b1;
            end
            if (resp_noise && $urandom_range(7) == 0) fir_output_valid = 1'b1;
        end
    end

    task automatic push(input logic [W-1:0] d);
        int guard = 0;
        bit rdy;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            rdy = s_ready;
            @(negedge clk);
            guard++;
        end while (!rdy && guard < 400);
        check("push_accept", rdy, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || fifo_count != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", busy || fifo_count != 0, 0);
    endtask

    task automatic check_got(input string name, input int base, input int cnt);
        logic [W-1:0] e;
        check({name, "_count"}, got.size(), cnt);
        for (int i = 0; i < cnt && i < got.size(); i++) begin
            e = W'(base + i);
            check({name, "_order"}, got[i], e);
        end
    endtask

    initial begin
        int n, strobes;
        rst = 1'b0; s_valid = 1'b0; s_data = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_s_ready", s_ready, 1);
        check("reset_fifo_count", fifo_count, 0);
        rst = 1'b0;

        // Single sample
        resp_delay = 10;
        got.delete();
        push(16'h1234);
        n = 0;
        while (!fir_input_valid && n < 10) begin @(negedge clk); n++; end
        check("single_strobe_edge", n, 1);
        check("single_din", fir_din, 16'h1234);
        check("single_busy", busy, 1);
        @(negedge clk);
        check("single_strobe_len", fir_input_valid, 0);
        wait_idle(100);
        check("single_issued", samples_issued, 16'd1);

        // Three back-to-back samples, slow FIR
        resp_delay = 64;
        got.delete();
        push(16'd1); push(16'd2); push(16'd3);
        wait_idle(1000);
        check_got("b2b", 1, 3);
        check("b2b_issued", samples_issued, 16'd4);

        // FIR stalls: fill the FIFO, then run into the timeout
        resp_delay = 0;
        got.delete();
        for (int i = 0; i < 9; i++) push(W'(101 + i));
        check("full_count", fifo_count, 8);
        check("full_s_ready", s_ready, 0);
        push(16'd110);
        check("timeout_set", timeout_err, 1);
        resp_delay = 5;
        wait_idle(3000);
        check_got("full", 101, 10);
        check("full_issued", samples_issued, 16'd14);
        check("timeout_sticky", timeout_err, 1);

        // Reset mid-WAIT with four samples queued
        resp_delay = 0;
        for (int i = 0; i < 5; i++) push(W'(201 + i));
        repeat (3) @(negedge clk);
        check("pre_reset_count", fifo_count, 4);
        #2 rst = 1'b1;
        #1;
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_strobe", fir_input_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_issued", samples_issued, 0);
        check("rst_din", fir_din, 0);
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fir_input_valid) strobes++;
        end
        check("post_reset_strobes", strobes, 0);

        // Wrap-around stream of 20 with a random, noisy FIR
        resp_rand = 1; resp_noise = 1;
        got.delete();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(3) == 0) @(negedge clk);
            push(W'(300 + i));
        end
        wait_idle(5000);
        check_got("wrap", 300, 20);
        check("wrap_issued", samples_issued, 16'd20);

        // Longer random soak
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            push(W'($urandom));
        end
        wait_idle(5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 Parameter InputWidth, default 16: sample width in bits, matching the FIR data input.
REQ-002 Parameter FifoDepth, default 8: sample FIFO depth; SHALL be a power of two, at least 2.
REQ-003 Parameter Timeout, default 128: maximum WAIT cycles allowed for a FIR result.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_data  input  InputWidth  upstream sample.
REQ-007 s_valid  input  1  upstream sample present.
REQ-008 s_ready  output  1  feeder can accept a sample this cycle.
REQ-009 fir_din  output  InputWidth  sample presented to the FIR.
REQ-010 fir_input_valid  output  1  one-cycle strobe: fir_din is valid.
REQ-011 fir_output_valid  input  1  FIR has finished the current sample.
REQ-012 busy  output  1  high while in ISSUE or WAIT.
REQ-013 fifo_count  output  $clog2(FifoDepth)+1  current FIFO occupancy.
REQ-014 timeout_err  output  1  sticky: a FIR result did not arrive within Timeout cycles.
REQ-015 samples_issued  output  16  count of samples strobed into the FIR; wraps modulo 2^16.

Function
REQ-016 FIFO push on any rising edge where s_valid and s_ready are both high; s_data is stored at the tail.
REQ-017 s_ready SHALL be combinational: high iff fifo_count < FifoDepth.
REQ-018 When full, s_ready is low and s_valid is ignored, with no overwrite and no error.
REQ-019 FSM states: IDLE, ISSUE, WAIT; all are registered.
REQ-020 IDLE -> ISSUE on the edge where registered fifo_count > 0: pop the head into fir_din, clear the timeout counter.
REQ-021 IDLE with fifo_count = 0: remain in IDLE.
REQ-022 A sample pushed into an empty FIFO SHALL NOT be popped on the same edge; it is popped no earlier than the next edge.
REQ-023 fir_input_valid SHALL be high exactly during the ISSUE cycle, one cycle per popped sample.
REQ-024 samples_issued increments on every ISSUE -> WAIT edge.
REQ-025 ISSUE -> WAIT unconditionally after one cycle; fir_din holds its value until the next pop.
REQ-026 WAIT with fir_output_valid high: go to ISSUE (and pop) if fifo_count > 0, else go to IDLE.
REQ-027 WAIT without fir_output_valid: increment the timeout counter.
REQ-028 When the timeout counter reaches Timeout-1 with no fir_output_valid: set timeout_err and go to IDLE.
REQ-029 fir_output_valid SHALL be ignored in IDLE and ISSUE.
REQ-030 A push and a pop on the same edge leave fifo_count unchanged.
REQ-031 Read and write pointers wrap modulo FifoDepth.
REQ-032 timeout_err, once set, stays set until rst; it does not stall further issuing.

Reset
REQ-033 rst high asynchronously forces: state IDLE; fifo_count 0; both FIFO pointers 0; fir_din 0; fir_input_valid 0; busy 0; timeout_err 0; samples_issued 0; timeout counter 0.
REQ-034 While rst is high, s_ready SHALL be high because fifo_count is 0.
REQ-035 Reset asserted mid-operation discards all queued samples and any in-flight sample, with no trailing strobe.
REQ-036 The first push is accepted on the first rising edge after rst deasserts.

Verification
REQ-037 Single sample: push 16'h1234 at edge k -> fir_input_valid high for one cycle starting at edge k+1, fir_din=16'h1234, busy high until fir_output_valid; then samples_issued=1.
REQ-038 Back-to-back: queue 3 samples 1,2,3; FIR returns fir_output_valid 64 cycles after each strobe -> exactly 3 strobes in order; each later strobe occurs on the edge after fir_output_valid; samples_issued=3.
REQ-039 Full FIFO with FIR stalled: push 9 samples with s_valid held high -> fifo_count reaches 8 (one sample is in flight); s_ready goes low; the extra sample is held upstream; no data is lost or duplicated.
REQ-040 Timeout: strobe issued and fir_output_valid never arrives -> timeout_err set after 128 WAIT cycles; state returns to IDLE; the next queued sample is strobed normally.
REQ-041 Reset mid-WAIT with 4 queued samples -> all outputs reach their reset values immediately; s_ready=1; no strobe follows release.
REQ-042 Wrap-around: stream 20 samples through FifoDepth=8 -> output order equals input order; fifo_count never exceeds 8; samples_issued=20.
